load_extend_ctrl: RTL and testbench
===================================

LOAD_EXTEND_CTRL -- requirements
Module: load_extend_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, max cycles in REQ waiting for mem_ack before abort (range 1..255).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  load request strobe, sampled in IDLE only.
REQ-005 Port: ld_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes illegal.
REQ-006 Port: addr  input  32  byte address of load, sampled with start.
REQ-007 Port: mem_req  output  1  data-memory read request.
REQ-008 Port: mem_addr  output  32  word address {addr_q[31:2],2'b00}.
REQ-009 Port: mem_ack  input  1  memory read-data-valid strobe.
REQ-010 Port: mem_rdata  input  32  memory read word, valid with mem_ack.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: done  output  1  one-cycle pulse, data_out updated.
REQ-013 Port: err  output  1  one-cycle pulse, load aborted.
REQ-014 Port: err_code  output  2  01 misaligned, 10 timeout, 11 illegal ld_type; held until next err.
REQ-015 Port: data_out  output  32  extended load result, held until next done.

Function
REQ-016 States SHALL be IDLE, REQ, DONE, ERR, encoded in a registered state variable.
REQ-017 IDLE: start=1 SHALL register addr, ld_type; illegal type or misalignment (LH/LHU addr[0]=1; LW addr[1:0]!=0) -> ERR, else -> REQ.
REQ-018 REQ: mem_req=1, mem_addr from registered addr; mem_ack=1 -> DONE and capture extended result into data_out on the same edge.
REQ-019 REQ: timeout counter SHALL clear on REQ entry, increment each REQ cycle without ack; reaching TIMEOUT_CYC without ack -> ERR, code 10.
REQ-020 mem_ack in the same cycle the counter reaches TIMEOUT_CYC SHALL take priority (ack wins, no error).
REQ-021 DONE: done=1 for one cycle, -> IDLE; ERR: err=1 for one cycle, err_code updated, -> IDLE; data_out unchanged on error.
REQ-022 Lane select, little-endian: byte = mem_rdata[8*addr_q[1:0] +: 8]; half = addr_q[1] ? [31:16] : [15:0].
REQ-023 LB/LH SHALL sign-extend (replicate bit 7/15) to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL pass word unchanged.
REQ-024 Latency: start at cycle N -> mem_req first high N+1; ack at cycle M -> done high M+1; minimum start-to-done 3 cycles; error-check failure -> err at N+1... N+2 (ERR entered N+1, err high N+1).
REQ-025 start while busy SHALL be ignored (no queueing); mem_ack outside REQ SHALL be ignored.
REQ-026 start in the IDLE cycle following DONE/ERR SHALL be accepted (back-to-back throughput one load per 3 cycles).

Reset
REQ-027 rst_n=0 at any time SHALL immediately force IDLE; mem_req, busy, done, err = 0; err_code = 00; data_out = 0; counter = 0; mem_addr = 0.
REQ-028 Reset mid-REQ SHALL abandon the load; a mem_ack arriving after release SHALL be ignored.
REQ-029 First start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-030 LB addr=0x1003, ack after 2 cycles, mem_rdata=0x80FF_1234 -> mem_addr=0x1000, done, data_out=0xFFFF_FF80.
REQ-031 LHU addr=0x2002, mem_rdata=0x8001_0000 -> data_out=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-032 LW addr=0x3001 -> no mem_req, err pulse, err_code=01, data_out unchanged; ld_type=011 -> err_code=11.
REQ-033 LW addr=0x4000, no ack, TIMEOUT_CYC=4 -> mem_req high 4 cycles, err, err_code=10, busy drops next cycle.
REQ-034 rst_n low during REQ, then ack after release -> outputs zero, no done, state IDLE.
REQ-035 start held high during LW ack at same cycle as timeout expiry -> done (not err), second start accepted only in following IDLE cycle.

Source files
------------

// File: rtl/load_extend_ctrl.sv
// Load controller: issues one aligned word read, then extracts and extends
// the addressed byte/half/word lane. Aborts on bad type, misalignment or timeout.
module load_extend_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  ld_type,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] data_out
);

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] EC_MISALIGN = 2'b01;
  localparam logic [1:0] EC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EC_ILLEGAL  = 2'b11;

  // Counter value on the last permitted REQ cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  type_q, type_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  code_q, code_d;
  logic        mem_req_q, mem_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  function automatic logic [31:0] extend_lane(input logic [2:0]  t,
                                              input logic [1:0]  a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      LD_LB:   extend_lane = {{24{b[7]}}, b};
      LD_LH:   extend_lane = {{16{h[15]}}, h};
      LD_LBU:  extend_lane = {24'd0, b};
      LD_LHU:  extend_lane = {16'd0, h};
      default: extend_lane = w;
    endcase
  endfunction

  function automatic logic type_legal(input logic [2:0] t);
    type_legal = (t == LD_LB) || (t == LD_LH) || (t == LD_LW) ||
                 (t == LD_LBU) || (t == LD_LHU);
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    misaligned = (((t == LD_LH) || (t == LD_LHU)) && a[0]) ||
                 ((t == LD_LW) && (a != 2'b00));
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = addr;
          type_d = ld_type;
          cnt_d  = 8'd0;
          // An illegal type is reported ahead of any alignment problem.
          if (!type_legal(ld_type)) begin
            code_d  = EC_ILLEGAL;
            state_d = S_ERR;
          end else if (misaligned(ld_type, addr[1:0])) begin
            code_d  = EC_MISALIGN;
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Ack wins even on the cycle the timeout would otherwise fire.
        if (mem_ack) begin
          data_d  = extend_lane(type_q, addr_q[1:0], mem_rdata);
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = EC_TIMEOUT;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      type_q    <= 3'd0;
      cnt_q     <= 8'd0;
      data_q    <= 32'd0;
      code_q    <= 2'b00;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      code_q    <= code_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Bench for load_extend_ctrl: directed loads against a transaction-level model
// checked every cycle, plus hand-computed literal expectations.
module tb_load_extend_ctrl;

  localparam int TO = 4;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                         LBU = 3'b100, LHU = 3'b101, LBAD = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  ld_type = 3'd0;
  logic [31:0] addr = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, busy, done, err;
  logic [31:0] mem_addr, data_out;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;
  int err_seen = 0;
  int req_seen = 0;

  load_extend_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_type(ld_type), .addr(addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected load result from plain shift/mask arithmetic on the word.
  function automatic logic [31:0] m_ext(input int t, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] bv, hv;
    bv = (w >> (8 * (a % 4))) & 32'hFF;
    hv = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (t)
      0:       return (bv >= 128) ? bv - 32'd256 : bv;
      1:       return (hv >= 32768) ? hv - 32'h10000 : hv;
      4:       return bv;
      5:       return hv;
      default: return w;
    endcase
  endfunction

  // Model: check this cycle's outputs, then predict the next cycle's.
  initial begin
    logic        m_active, e_req, e_busy, e_done, e_err, n_done, n_err;
    int          m_age, m_type;
    logic [31:0] m_addr, e_data, e_maddr;
    logic [1:0]  e_code;
    m_active = 0; e_req = 0; e_busy = 0; e_done = 0; e_err = 0;
    m_age = 0; m_type = 0; m_addr = 0; e_data = 0; e_maddr = 0; e_code = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 0; e_req = 0; e_busy = 0; e_done = 0; e_err = 0;
        m_age = 0; m_type = 0; m_addr = 0; e_data = 0; e_maddr = 0; e_code = 0;
      end
      chk("mem_req", mem_req, e_req);
      chk("mem_addr", mem_addr, e_maddr);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("err_code", err_code, e_code);
      chk("data_out", data_out, e_data);
      if (done) done_seen++;
      if (err) err_seen++;
      if (mem_req) req_seen++;

      n_done = 0;
      n_err = 0;
      if (!rst_n) begin
        n_done = 0;
      end else if (m_active) begin
        if (mem_ack) begin
          e_data = m_ext(m_type, m_addr, mem_rdata);
          n_done = 1;
          m_active = 0;
          $display("txn load type=%0d addr=%h data=%h", m_type, m_addr, e_data);
        end else if (m_age + 1 >= TO) begin
          e_code = 2'b10;
          n_err = 1;
          m_active = 0;
          $display("txn timeout addr=%h", m_addr);
        end else begin
          m_age++;
        end
      end else if (!e_busy && start) begin
        m_type = int'(ld_type);
        m_addr = addr;
        e_maddr = addr & 32'hFFFF_FFFC;
        if (!(m_type inside {0, 1, 2, 4, 5})) begin
          e_code = 2'b11;
          n_err = 1;
        end else if ((m_type % 4 == 1 && addr % 2 != 0) || (m_type == 2 && addr % 4 != 0)) begin
          e_code = 2'b01;
          n_err = 1;
        end else begin
          m_active = 1;
          m_age = 0;
        end
        if (n_err) $display("txn reject type=%0d addr=%h code=%0d", m_type, addr, e_code);
      end
      e_done = n_done;
      e_err = n_err;
      e_req = m_active;
      e_busy = m_active || n_done || n_err;
    end
  end

  task automatic step(input logic s, input logic [2:0] t, input logic [31:0] a,
                      input logic k, input logic [31:0] d);
    @(posedge clk);
    #1;
    start = s; ld_type = t; addr = a; mem_ack = k; mem_rdata = d;
  endtask

  task automatic load(input logic [2:0] t, input logic [31:0] a, input int waits,
                      input logic [31:0] d);
    step(1'b1, t, a, 1'b0, 32'd0);
    repeat (waits) step(1'b0, t, a, 1'b0, 32'd0);
    step(1'b0, t, a, 1'b1, d);
    step(1'b0, t, a, 1'b0, 32'd0);
    step(1'b0, t, a, 1'b0, 32'd0);
  endtask

  task automatic bad_load(input logic [2:0] t, input logic [31:0] a);
    step(1'b1, t, a, 1'b0, 32'd0);
    step(1'b0, t, a, 1'b0, 32'd0);
    step(1'b0, t, a, 1'b0, 32'd0);
  endtask

  initial begin
    int d0, e0, r0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst data_out", data_out, 32'd0);
    chk("rst err_code", err_code, 32'd0);
    chk("rst busy", busy, 32'd0);

    // Release reset with start already high: first edge must accept.
    @(posedge clk);
    #1;
    rst_n = 1; start = 1; ld_type = LB; addr = 32'h0000_1003;
    step(1'b0, LB, 32'h1003, 1'b0, 32'd0);
    @(negedge clk);
    chk("lb mem_addr", mem_addr, 32'h0000_1000);
    step(1'b0, LB, 32'h1003, 1'b0, 32'd0);
    step(1'b0, LB, 32'h1003, 1'b1, 32'h80FF_1234);
    step(1'b0, LB, 32'h1003, 1'b0, 32'd0);
    step(1'b0, LB, 32'h1003, 1'b0, 32'd0);
    chk("lb data", data_out, 32'hFFFF_FF80);
    chk("lb done count", done_seen, 1);

    load(LHU, 32'h2002, 0, 32'h8001_0000);
    chk("lhu data", data_out, 32'h0000_8001);
    load(LH, 32'h2002, 1, 32'h8001_0000);
    chk("lh data", data_out, 32'hFFFF_8001);

    r0 = req_seen;
    bad_load(LW, 32'h3001);
    chk("misalign code", err_code, 32'd1);
    chk("misalign data held", data_out, 32'hFFFF_8001);
    chk("misalign no req", req_seen - r0, 0);
    bad_load(LBAD, 32'h3000);
    chk("illegal code", err_code, 32'd3);

    r0 = req_seen; e0 = err_seen;
    step(1'b1, LW, 32'h4000, 1'b0, 32'd0);
    repeat (6) step(1'b0, LW, 32'h4000, 1'b0, 32'd0);
    chk("timeout req cycles", req_seen - r0, 4);
    chk("timeout err count", err_seen - e0, 1);
    chk("timeout code", err_code, 32'd2);
    chk("timeout busy after", busy, 32'd0);

    // Stray ack while idle.
    step(1'b0, LW, 32'h0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, LW, 32'h0, 1'b0, 32'd0);

    d0 = done_seen;
    step(1'b1, LW, 32'h5000, 1'b0, 32'd0);
    step(1'b0, LW, 32'h5000, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1; mem_ack = 1; mem_rdata = 32'h1234_5678;
    step(1'b0, LW, 32'h5000, 1'b0, 32'd0);
    step(1'b0, LW, 32'h5000, 1'b0, 32'd0);
    chk("rst mid data", data_out, 32'd0);
    chk("rst mid no done", done_seen - d0, 0);
    chk("rst mid idle", busy, 32'd0);
    chk("rst mid mem_addr", mem_addr, 32'd0);

    // Ack on the final timeout cycle with start held high throughout.
    d0 = done_seen; e0 = err_seen;
    step(1'b1, LW, 32'h6000, 1'b0, 32'd0);
    repeat (3) step(1'b1, LW, 32'h6000, 1'b0, 32'd0);
    step(1'b1, LW, 32'h6000, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, LBU, 32'h6001, 1'b0, 32'd0);
    chk("race done", done, 32'd1);
    chk("race data", data_out, 32'hDEAD_BEEF);
    step(1'b1, LBU, 32'h6001, 1'b0, 32'd0);
    step(1'b0, LBU, 32'h6001, 1'b1, 32'h0000_C300);
    step(1'b0, LBU, 32'h6001, 1'b0, 32'd0);
    step(1'b0, LBU, 32'h6001, 1'b0, 32'd0);
    chk("race second data", data_out, 32'h0000_00C3);
    chk("race done count", done_seen - d0, 2);
    chk("race no err", err_seen - e0, 0);

    load(LB, 32'h7002, 0, 32'h12AB_3456);
    chk("lb lane2", data_out, 32'hFFFF_FFAB);
    load(LBU, 32'h7001, 1, 32'h12AB_3456);
    chk("lbu lane1", data_out, 32'h0000_0034);
    load(LW, 32'h7000, 2, 32'h89AB_CDEF);
    chk("lw word", data_out, 32'h89AB_CDEF);
    load(LB, 32'h7000, 0, 32'h0000_007F);
    chk("lb positive", data_out, 32'h0000_007F);
    load(LHU, 32'h7000, 0, 32'h1234_F00D);
    chk("lhu low half", data_out, 32'h0000_F00D);

    step(1'b0, LB, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
